// File: rtl/rv_trace_buf.sv
// -----------------------------------------------------------------------------
// rv_trace_buf
//   Retire-trace capture unit for the RV core. A shadow pipeline follows every
//   instruction from decode to writeback, applying the same stall and flush
//   decisions as the core. Each retired instruction can be recorded in a
//   circular buffer that a debug transport drains through a first-word
//   fall-through valid/ready port. A small arm/trigger FSM decides which
//   retires are recorded.
//
// Build option:
//   RV_TRACE_TS_EN  defined   -> free-running timestamp counter, one stored
//                                timestamp per entry, shown on o_rd_ts.
//                   undefined -> no counter and no storage; o_rd_ts is 0.
//
// Parameters:
//   RESET_ADDR   PC loaded into the decode slot when decode is flushed
//   PIPE_STAGES  slots from decode to writeback inclusive (3..8)
//   DEPTH        buffer entries (power of 2, >= 4)
//   TS_WIDTH     timestamp width
//
// Ports:
//   i_clk, i_reset_n             clock, asynchronous active-low reset
//   i_pc, i_instr                fetch PC (word address) and instruction
//   i_reg_write/i_mem_write/
//   i_mem_read                   decode-stage flags
//   i_decode_stall/i_decode_flush/
//   i_exec_flush/i_decode_jump_imm  pipeline control
//   i_reg_data                   writeback data (valid in the writeback cycle)
//   i_arm, i_stop                capture control pulses
//   i_mode                       0 = stop when full, 1 = ring (overwrite oldest)
//   i_trig_en, i_trig_pc         PC trigger
//   o_rd_valid, i_rd_ready       read handshake (pop on valid & ready)
//   o_rd_pc/o_rd_instr/o_rd_data/
//   o_rd_flags/o_rd_ts           head entry ({mem_read, mem_write, reg_write})
//   o_count                      occupancy
//   o_overflow                   sticky: an entry was lost or overwritten
//   o_state                      0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
// -----------------------------------------------------------------------------
module rv_trace_buf #(
  parameter logic [31:0] RESET_ADDR  = 32'h0000_0000,
  parameter int          PIPE_STAGES = 4,
  parameter int          DEPTH       = 64,
  parameter int          TS_WIDTH    = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [31:2]            i_pc,
  input  logic [31:0]            i_instr,
  input  logic                   i_reg_write,
  input  logic                   i_mem_write,
  input  logic                   i_mem_read,
  input  logic                   i_decode_stall,
  input  logic                   i_decode_flush,
  input  logic                   i_exec_flush,
  input  logic                   i_decode_jump_imm,
  input  logic [31:0]            i_reg_data,
  input  logic                   i_arm,
  input  logic                   i_stop,
  input  logic                   i_mode,
  input  logic                   i_trig_en,
  input  logic [31:0]            i_trig_pc,
  output logic                   o_rd_valid,
  input  logic                   i_rd_ready,
  output logic [31:0]            o_rd_pc,
  output logic [31:0]            o_rd_instr,
  output logic [31:0]            o_rd_data,
  output logic [2:0]             o_rd_flags,
  output logic [TS_WIDTH-1:0]    o_rd_ts,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow,
  output logic [1:0]             o_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WB    = PIPE_STAGES - 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Shadow pipeline slots: index 0 is decode, 1 is exec, WB is writeback.
  logic        slot_vld_q   [PIPE_STAGES];
  logic        slot_vld_d   [PIPE_STAGES];
  logic [31:0] slot_pc_q    [PIPE_STAGES];
  logic [31:0] slot_pc_d    [PIPE_STAGES];
  logic [31:0] slot_instr_q [PIPE_STAGES];
  logic [31:0] slot_instr_d [PIPE_STAGES];
  logic [2:0]  slot_flags_q [PIPE_STAGES];
  logic [2:0]  slot_flags_d [PIPE_STAGES];

  // Buffer storage (data only, never reset) and its control state.
  logic [31:0] mem_pc    [DEPTH];
  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_data  [DEPTH];
  logic [2:0]  mem_flags [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  state_t           state_q, state_d;

`ifdef RV_TRACE_TS_EN
  logic [TS_WIDTH-1:0] mem_ts [DEPTH];
  logic [TS_WIDTH-1:0] ts_q, ts_d;
`endif

  logic retire;
  logic trig_hit;
  logic push;
  logic pop;
  logic full;
  logic rd_valid;
  logic wr_en;
  logic lost;
  logic arm_clr;

  // ---------------------------------------------------------------------------
  // Shadow pipeline next state
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < PIPE_STAGES; i++) begin
      slot_vld_d[i]   = slot_vld_q[i];
      slot_pc_d[i]    = slot_pc_q[i];
      slot_instr_d[i] = slot_instr_q[i];
      slot_flags_d[i] = slot_flags_q[i];
    end

    // Decode: flush beats stall; a stalled slot simply holds.
    if (i_decode_flush) begin
      slot_vld_d[0]   = 1'b0;
      slot_pc_d[0]    = RESET_ADDR;
      slot_instr_d[0] = 32'h0;
      slot_flags_d[0] = 3'b000;
    end else if (!i_decode_stall) begin
      slot_vld_d[0]   = 1'b1;
      slot_pc_d[0]    = {i_pc, 2'b00};
      slot_instr_d[0] = i_instr;
      slot_flags_d[0] = {i_mem_read, i_mem_write, i_reg_write};
    end

    // Exec: payload always follows decode; only the valid bit is gated.
    // A stalled decode slot still holds its instruction, so exec must take a
    // bubble or the instruction would retire twice. A jump resolved at decode
    // keeps the instruction already in flight despite the exec flush.
    slot_pc_d[1]    = slot_pc_q[0];
    slot_instr_d[1] = slot_instr_q[0];
    slot_flags_d[1] = slot_flags_q[0];
    slot_vld_d[1]   = slot_vld_q[0] && !i_decode_stall &&
                      !(i_exec_flush && !i_decode_jump_imm);

    for (int i = 2; i < PIPE_STAGES; i++) begin
      slot_vld_d[i]   = slot_vld_q[i-1];
      slot_pc_d[i]    = slot_pc_q[i-1];
      slot_instr_d[i] = slot_instr_q[i-1];
      slot_flags_d[i] = slot_flags_q[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        slot_vld_q[i]   <= 1'b0;
        slot_pc_q[i]    <= (i == 0) ? RESET_ADDR : 32'h0;
        slot_instr_q[i] <= 32'h0;
        slot_flags_q[i] <= 3'b000;
      end
    end else begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        slot_vld_q[i]   <= slot_vld_d[i];
        slot_pc_q[i]    <= slot_pc_d[i];
        slot_instr_q[i] <= slot_instr_d[i];
        slot_flags_q[i] <= slot_flags_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Writeback: retire detection and push decision
  // ---------------------------------------------------------------------------
  always_comb begin
    // A zero instruction word is a pipeline filler, not a real retire.
    retire   = slot_vld_q[WB] && (slot_instr_q[WB] != 32'h0);
    trig_hit = slot_pc_q[WB] == i_trig_pc;
    // In ARMED only the trigger retire is recorded, and a stop in the same
    // cycle cancels the trigger.
    push     = retire && ((state_q == ST_CAPTURE) ||
                          (state_q == ST_ARMED && trig_hit && !i_stop));
  end

  // ---------------------------------------------------------------------------
  // Buffer pointers, occupancy and overflow
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_valid = count_q != '0;
    full     = count_q == CNT_W'(DEPTH);
    pop      = rd_valid && i_rd_ready;
    // When full and nothing is popped, ring mode overwrites the slot under
    // rd_ptr (wr_ptr == rd_ptr when full); stop mode drops the entry.
    wr_en    = push && (!full || pop || i_mode);
    lost     = push && full && !pop;

    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = (pop || (wr_en && full)) ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    if (wr_en && !full && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !wr_en) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    arm_clr = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_arm && !i_stop) begin
          state_d = i_trig_en ? ST_ARMED : ST_CAPTURE;
          arm_clr = 1'b1;
        end
      end
      ST_ARMED: begin
        if (i_stop) begin
          state_d = ST_DONE;
        end else if (push) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (i_stop) begin
          state_d = ST_DONE;
        end else if (!i_mode && push && count_d == CNT_W'(DEPTH)) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    overflow_d = arm_clr ? 1'b0 : (overflow_q || lost);
  end

`ifdef RV_TRACE_TS_EN
  always_comb begin
    ts_d = ts_q + TS_WIDTH'(1);
  end
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
`ifdef RV_TRACE_TS_EN
      ts_q       <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
`ifdef RV_TRACE_TS_EN
      ts_q       <= ts_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer write (data path, no reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_pc[wr_ptr_q]    <= slot_pc_q[WB];
      mem_instr[wr_ptr_q] <= slot_instr_q[WB];
      mem_data[wr_ptr_q]  <= i_reg_data;
      mem_flags[wr_ptr_q] <= slot_flags_q[WB];
`ifdef RV_TRACE_TS_EN
      mem_ts[wr_ptr_q]    <= ts_q;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Read port: fall-through head, forced to zero while empty so that stale
  // (unreset) storage never shows on the outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_rd_valid = rd_valid;
    o_rd_pc    = 32'h0;
    o_rd_instr = 32'h0;
    o_rd_data  = 32'h0;
    o_rd_flags = 3'b000;
    o_rd_ts    = '0;
    if (rd_valid) begin
      o_rd_pc    = mem_pc[rd_ptr_q];
      o_rd_instr = mem_instr[rd_ptr_q];
      o_rd_data  = mem_data[rd_ptr_q];
      o_rd_flags = mem_flags[rd_ptr_q];
`ifdef RV_TRACE_TS_EN
      o_rd_ts    = mem_ts[rd_ptr_q];
`endif
    end
    o_count    = count_q;
    o_overflow = overflow_q;
    o_state    = state_q;
  end

endmodule
